// File: rtl/fir_tap_scheduler.sv
// Sequencer for the time-multiplexed FIR datapath: LOAD -> N MAC cycles -> DONE handshake.
// Optional feature macro: FIR_DROP_CNT_EN adds a saturating drop_cnt[7:0] output.
module fir_tap_scheduler #(
  parameter int N = 3,
  localparam int TW = $clog2(N) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_strobe,
  output logic          shift_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [N-1:0]  tap_sel,
  output logic [TW-1:0] tap_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          drop
`ifdef FIR_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  // Handshake: out_valid stays high until out_ready is sampled high; that edge
  // completes the transfer. out_ready is ignored whenever out_valid is low.
  state_t        state, nextState;
  logic [TW-1:0] tapK, nextTapK;
  logic          dropNext;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      tapK  <= '0;
      drop  <= 1'b0;
    end else begin
      state <= nextState;
      tapK  <= nextTapK;
      drop  <= dropNext;
    end
  end

  always_comb begin
    nextState = state;
    nextTapK  = tapK;
    unique case (state)
      IDLE: if (in_strobe) nextState = LOAD;
      LOAD: begin
        nextState = MAC;
        nextTapK  = '0;
      end
      MAC: begin
        if (tapK == TW'(N - 1)) begin
          nextState = DONE;
          nextTapK  = '0;
        end else begin
          nextTapK = tapK + TW'(1);
        end
      end
      DONE: if (out_ready) nextState = in_strobe ? LOAD : IDLE;
      default: nextState = IDLE;
    endcase
    // A strobe is only consumed in IDLE or on the DONE handshake edge.
    dropNext = in_strobe && (state != IDLE) && !((state == DONE) && out_ready);
  end

  always_comb begin
    shift_en  = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    tap_sel   = '0;
    tap_idx   = '0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      LOAD: begin
        shift_en = 1'b1;
        acc_clr  = 1'b1;
      end
      MAC: begin
        acc_en  = 1'b1;
        tap_sel = N'(1) << tapK;
        tap_idx = tapK;
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef FIR_DROP_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt <= 8'h00;
    end else if (dropNext && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Bench for fir_tap_scheduler: an N=3 and an N=1 instance on shared inputs, checked
// against a table of hand-derived vectors and a phase-count reference model.
module tb_fir_tap_scheduler;

  logic CLK = 1'b0;
  logic RST;
  logic in_strobe, out_ready;

  logic       shift3, clr3, en3, valid3, busy3, drop3;
  logic [2:0] sel3, idx3;
  logic       shift1, clr1, en1, valid1, busy1, drop1;
  logic [0:0] sel1, idx1;

  fir_tap_scheduler #(.N(3)) u3 (
    .CLK(CLK), .RST(RST), .in_strobe(in_strobe),
    .shift_en(shift3), .acc_clr(clr3), .acc_en(en3), .tap_sel(sel3), .tap_idx(idx3),
    .out_valid(valid3), .out_ready(out_ready), .busy(busy3), .drop(drop3)
  );

  fir_tap_scheduler #(.N(1)) u1 (
    .CLK(CLK), .RST(RST), .in_strobe(in_strobe),
    .shift_en(shift1), .acc_clr(clr1), .acc_en(en1), .tap_sel(sel1), .tap_idx(idx1),
    .out_valid(valid1), .out_ready(out_ready), .busy(busy1), .drop(drop1)
  );

  always #5 CLK = ~CLK;

  int vecCnt  = 0;
  int missCnt = 0;

  // Reference model: phase = cycles since the sample was accepted
  // (0 idle, 1 load, 2..n+1 tap phase-2, n+2 result waiting).
  int   ph3, ph1;
  logic dr3, dr1;

  typedef struct {
    logic        strobe;
    logic        ready;
    logic [12:0] exp;
  } vec_t;
  vec_t tab[22];

  function automatic logic [12:0] pk(bit sh, bit cl, bit en, bit va, bit bu, bit dr,
                                     int sel, int idx);
    return {sh, cl, en, va, bu, dr, 4'(sel), 3'(idx)};
  endfunction

  function automatic logic [12:0] modelOut(int phase, int n, logic drp);
    bit inMac;
    inMac = (phase >= 2) && (phase <= n + 1);
    return pk(phase == 1, phase == 1, inMac, phase == n + 2, phase != 0, drp,
              inMac ? (1 << (phase - 2)) : 0, inMac ? phase - 2 : 0);
  endfunction

  function automatic int nextPhase(int phase, int n, logic s, logic r);
    if (phase == 0) return s ? 1 : 0;
    if (phase < n + 2) return phase + 1;
    if (r) return s ? 1 : 0;
    return phase;
  endfunction

  function automatic logic nextDrop(int phase, int n, logic s, logic r);
    return s && (phase != 0) && !((phase == n + 2) && r);
  endfunction

  function automatic logic [12:0] act3();
    return pk(shift3, clr3, en3, valid3, busy3, drop3, int'(sel3), int'(idx3));
  endfunction

  function automatic logic [12:0] act1();
    return pk(shift1, clr1, en1, valid1, busy1, drop1, int'(sel1), int'(idx1));
  endfunction

  task automatic cmp(input string name, input logic [12:0] act, input logic [12:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("FAIL %s @%0t: got %b required %b (sh,clr,en,val,busy,drop,sel4,idx3)",
               name, $time, act, exp);
    end
  endtask

  // Drive inputs for one cycle, check mid-cycle, then advance the models.
  task automatic step(input logic s, input logic r, input bit useTab,
                      input logic [12:0] tabExp, input string name);
    in_strobe = s;
    out_ready = r;
    @(negedge CLK);
    cmp({name, "_n3"}, act3(), useTab ? tabExp : modelOut(ph3, 3, dr3));
    cmp({name, "_n1"}, act1(), modelOut(ph1, 1, dr1));
    @(posedge CLK);
    dr3 = nextDrop(ph3, 3, s, r);
    ph3 = nextPhase(ph3, 3, s, r);
    dr1 = nextDrop(ph1, 1, s, r);
    ph1 = nextPhase(ph1, 1, s, r);
    #1;
  endtask

  task automatic modelReset();
    ph3 = 0; ph1 = 0; dr3 = 1'b0; dr1 = 1'b0;
  endtask

  initial begin
    tab[0]  = '{1, 1, pk(0,0,0,0,0,0,0,0)};
    tab[1]  = '{0, 1, pk(1,1,0,0,1,0,0,0)};
    tab[2]  = '{0, 1, pk(0,0,1,0,1,0,1,0)};
    tab[3]  = '{0, 1, pk(0,0,1,0,1,0,2,1)};
    tab[4]  = '{0, 1, pk(0,0,1,0,1,0,4,2)};
    tab[5]  = '{0, 1, pk(0,0,0,1,1,0,0,0)};
    tab[6]  = '{1, 0, pk(0,0,0,0,0,0,0,0)};
    tab[7]  = '{0, 0, pk(1,1,0,0,1,0,0,0)};
    tab[8]  = '{0, 0, pk(0,0,1,0,1,0,1,0)};
    tab[9]  = '{0, 0, pk(0,0,1,0,1,0,2,1)};
    tab[10] = '{0, 0, pk(0,0,1,0,1,0,4,2)};
    tab[11] = '{0, 0, pk(0,0,0,1,1,0,0,0)};
    tab[12] = '{1, 0, pk(0,0,0,1,1,0,0,0)};
    tab[13] = '{0, 0, pk(0,0,0,1,1,1,0,0)};
    tab[14] = '{0, 0, pk(0,0,0,1,1,0,0,0)};
    tab[15] = '{1, 1, pk(0,0,0,1,1,0,0,0)};
    tab[16] = '{0, 1, pk(1,1,0,0,1,0,0,0)};
    tab[17] = '{0, 1, pk(0,0,1,0,1,0,1,0)};
    tab[18] = '{1, 1, pk(0,0,1,0,1,0,2,1)};
    tab[19] = '{0, 1, pk(0,0,1,0,1,1,4,2)};
    tab[20] = '{0, 1, pk(0,0,0,1,1,0,0,0)};
    tab[21] = '{0, 1, pk(0,0,0,0,0,0,0,0)};

    // Clock/reset
    RST = 1'b1;
    in_strobe = 1'b0;
    out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    cmp("reset_n3", act3(), 13'd0);
    cmp("reset_n1", act1(), 13'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Directed table: single sample, held result, back-to-back strobe, drops
    for (int i = 0; i < 22; i++) begin
      step(tab[i].strobe, tab[i].ready, 1'b1, tab[i].exp, $sformatf("tab%0d", i));
    end

    // Asynchronous reset while the N=3 instance sits on tap k=1
    step(1, 1, 1'b0, '0, "pre_rst");
    step(0, 1, 1'b0, '0, "pre_rst");
    step(0, 1, 1'b0, '0, "pre_rst");
    cmp("mid_mac_k1", act3(), pk(0,0,1,0,1,0,2,1));
    #2;
    RST = 1'b1;
    #1;
    cmp("async_rst_n3", act3(), 13'd0);
    cmp("async_rst_n1", act1(), 13'd0);
    @(negedge CLK);
    RST = 1'b0;
    modelReset();
    @(posedge CLK);
    #1;
    step(0, 1, 1'b0, '0, "post_rst");
    step(0, 1, 1'b0, '0, "post_rst");

    // Strobe every second cycle: most land in LOAD/MAC and are dropped
    for (int i = 0; i < 24; i++) begin
      step(i % 2 == 0, 1, 1'b0, '0, "every2");
    end

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 1'b0, '0, "rand");
    end

    // Drain: ready high, no strobes, both back to idle
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1'b0, '0, "drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
